// File: rtl/pe_pkg.sv
// Shared constants and types for the conv2d PE front end.
package pe_pkg;

    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] INT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ACT_INLIER,
        ACT_OUTLIER,
        ACT_CLAMPED
    } act_class_e;

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } state_e;

endpackage

// File: rtl/outlier_classify.sv
// Combinational per-word classification: magnitude test against the threshold,
// with saturation toward the sign's extreme once the outlier budget is spent.
module outlier_classify
    import pe_pkg::*;
#(
    parameter int DATA_W = pe_pkg::DATA_W
) (
    input  logic signed [DATA_W-1:0] x,
    input  logic        [DATA_W-1:0] thr,
    input  logic                     budget_left,
    output logic signed [DATA_W-1:0] data,
    output act_class_e               cls
);

    logic signed [DATA_W:0] sx;
    logic        [DATA_W:0] mag;

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    always_comb begin
        // One extra bit so that the most negative input has a representable magnitude
        sx   = {x[DATA_W-1], x};
        mag  = x[DATA_W-1] ? -sx : sx;
        data = x;
        cls  = ACT_INLIER;
        if (mag > {1'b0, thr}) begin
            if (budget_left) begin
                cls = ACT_OUTLIER;
            end else begin
                cls  = ACT_CLAMPED;
                data = saturate(x);
            end
        end
    end

endmodule

// File: rtl/act_outlier_classifier.sv
// Streams one activation tile, tags outliers against a per-tile latched threshold
// and budget, and reports per-tile outlier/clamp counts when the last word leaves.
module act_outlier_classifier
    import pe_pkg::*;
#(
    parameter int DATA_W   = pe_pkg::DATA_W,
    parameter int TILE_LEN = 27,
    parameter int M_W      = 8,
    parameter int CNT_W    = $clog2(TILE_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [DATA_W-1:0] cfg_threshold,
    input  logic [M_W-1:0]    cfg_m,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_outlier,
    output logic              out_clamped,
    output logic              out_last,
    output logic              tile_done,
    output logic [CNT_W-1:0]  tile_outliers,
    output logic [CNT_W-1:0]  tile_clamped
);

    localparam int CMP_W = (M_W > CNT_W) ? M_W : CNT_W;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         idx_q, idx_d, ocnt_q, ocnt_d, ccnt_q, ccnt_d;
    logic [CNT_W-1:0]         fin_out_q, fin_out_d, fin_clp_q, fin_clp_d;
    logic [CNT_W-1:0]         tile_outliers_q, tile_outliers_d, tile_clamped_q, tile_clamped_d;
    logic [DATA_W-1:0]        thr_q, thr_d, out_data_q, out_data_d;
    logic [M_W-1:0]           m_q, m_d;
    logic                     out_valid_q, out_valid_d, out_outlier_q, out_outlier_d;
    logic                     out_clamped_q, out_clamped_d, out_last_q, out_last_d;
    logic                     tile_done_q, tile_done_d;

    logic                     accept, is_last, budget_left, is_outlier, is_clamped;
    logic [DATA_W-1:0]        thr_eff;
    logic [M_W-1:0]           m_eff;
    logic [CMP_W-1:0]         ocnt_ext, m_ext;
    logic [CNT_W-1:0]         ocnt_nxt, ccnt_nxt;
    logic signed [DATA_W-1:0] cls_data;
    act_class_e               cls;

    assign in_ready = !clear && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_last  = (idx_q == CNT_W'(TILE_LEN - 1));

    // The first word of a tile sees the live config; later words see the latched copy
    assign thr_eff     = (state_q == IDLE) ? cfg_threshold : thr_q;
    assign m_eff       = (state_q == IDLE) ? cfg_m : m_q;
    assign ocnt_ext    = CMP_W'(ocnt_q);
    assign m_ext       = CMP_W'(m_eff);
    assign budget_left = (ocnt_ext < m_ext);

    outlier_classify #(.DATA_W(DATA_W)) u_classify (
        .x           (in_data),
        .thr         (thr_eff),
        .budget_left (budget_left),
        .data        (cls_data),
        .cls         (cls)
    );

    assign is_outlier = (cls == ACT_OUTLIER);
    assign is_clamped = (cls == ACT_CLAMPED);
    assign ocnt_nxt   = ocnt_q + CNT_W'(is_outlier);
    assign ccnt_nxt   = ccnt_q + CNT_W'(is_clamped);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ocnt_d        = ocnt_q;
        ccnt_d        = ccnt_q;
        thr_d         = thr_q;
        m_d           = m_q;
        fin_out_d     = fin_out_q;
        fin_clp_d     = fin_clp_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_outlier_d = out_outlier_q;
        out_clamped_d = out_clamped_q;
        out_last_d    = out_last_q;
        // Counts of the finishing tile are parked in fin_* until its last word is taken
        tile_done_d     = out_valid_q && out_ready && out_last_q;
        tile_outliers_d = tile_done_d ? fin_out_q : tile_outliers_q;
        tile_clamped_d  = tile_done_d ? fin_clp_q : tile_clamped_q;
        if (clear) begin
            state_d     = IDLE;
            idx_d       = '0;
            ocnt_d      = '0;
            ccnt_d      = '0;
            out_valid_d = 1'b0;
        end else begin
            if (out_ready) out_valid_d = 1'b0;
            if (accept) begin
                out_valid_d   = 1'b1;
                out_data_d    = cls_data;
                out_outlier_d = is_outlier;
                out_clamped_d = is_clamped;
                out_last_d    = is_last;
                if (state_q == IDLE) begin
                    thr_d = cfg_threshold;
                    m_d   = cfg_m;
                end
                if (is_last) begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    ocnt_d    = '0;
                    ccnt_d    = '0;
                    fin_out_d = ocnt_nxt;
                    fin_clp_d = ccnt_nxt;
                end else begin
                    state_d = RUN;
                    idx_d   = idx_q + CNT_W'(1);
                    ocnt_d  = ocnt_nxt;
                    ccnt_d  = ccnt_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            ocnt_q          <= '0;
            ccnt_q          <= '0;
            thr_q           <= '0;
            m_q             <= '0;
            fin_out_q       <= '0;
            fin_clp_q       <= '0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_outlier_q   <= 1'b0;
            out_clamped_q   <= 1'b0;
            out_last_q      <= 1'b0;
            tile_done_q     <= 1'b0;
            tile_outliers_q <= '0;
            tile_clamped_q  <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            ocnt_q          <= ocnt_d;
            ccnt_q          <= ccnt_d;
            thr_q           <= thr_d;
            m_q             <= m_d;
            fin_out_q       <= fin_out_d;
            fin_clp_q       <= fin_clp_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_outlier_q   <= out_outlier_d;
            out_clamped_q   <= out_clamped_d;
            out_last_q      <= out_last_d;
            tile_done_q     <= tile_done_d;
            tile_outliers_q <= tile_outliers_d;
            tile_clamped_q  <= tile_clamped_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_outlier   = out_outlier_q;
    assign out_clamped   = out_clamped_q;
    assign out_last      = out_last_q;
    assign tile_done     = tile_done_q;
    assign tile_outliers = tile_outliers_q;
    assign tile_clamped  = tile_clamped_q;

endmodule

// File: tb/tb_act_outlier_classifier.sv
// Randomized bench for act_outlier_classifier against a tile-level reference model.
module tb_act_outlier_classifier;

    localparam int DW = 32;
    localparam int TL = 4;
    localparam int MW = 8;
    localparam int CW = $clog2(TL + 1);

    logic          clk = 1'b0;
    logic          reset, clear, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] cfg_threshold, in_data, out_data;
    logic [MW-1:0] cfg_m;
    logic          out_outlier, out_clamped, out_last, tile_done;
    logic [CW-1:0] tile_outliers, tile_clamped;

    always #5 clk = ~clk;

    act_outlier_classifier #(.DATA_W(DW), .TILE_LEN(TL), .M_W(MW)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .cfg_threshold(cfg_threshold), .cfg_m(cfg_m),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_outlier(out_outlier), .out_clamped(out_clamped), .out_last(out_last),
        .tile_done(tile_done), .tile_outliers(tile_outliers), .tile_clamped(tile_clamped)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          o;
        logic          c;
        logic          l;
    } exp_t;

    int checks = 0;
    int errors = 0;

    // Reference model state: position in tile, per-tile counts, latched config
    int            m_idx, m_ocnt, m_ccnt, m_m;
    logic [DW-1:0] m_thr;
    int            fin_out, fin_clp, sum_out, sum_clp;

    function automatic void model_reset();
        m_idx = 0; m_ocnt = 0; m_ccnt = 0;
    endfunction

    function automatic exp_t mdl(input logic [DW-1:0] x);
        exp_t   e;
        longint v, mag;
        if (m_idx == 0) begin
            m_thr = cfg_threshold;
            m_m   = int'(cfg_m);
        end
        v   = longint'($signed(x));
        mag = (v < 0) ? -v : v;
        e.d = x; e.o = 1'b0; e.c = 1'b0;
        if (mag > longint'(m_thr)) begin
            if (m_ocnt < m_m) begin
                e.o = 1'b1; m_ocnt++;
            end else begin
                e.c = 1'b1; m_ccnt++;
                e.d = (v < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end
        e.l = (m_idx == TL - 1);
        if (e.l) begin
            fin_out = m_ocnt; fin_clp = m_ccnt;
            model_reset();
        end else begin
            m_idx++;
        end
        return e;
    endfunction

    // Presents one word at a falling edge; returns at the next falling edge
    task automatic drive(input logic [DW-1:0] x, output exp_t e);
        in_valid = 1'b1;
        in_data  = x;
        e        = mdl(x);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 32'h8000_0000;
        if (sel == 1) return 32'h7FFF_FFFF;
        return DW'($signed($urandom_range(0, 4000)) - 2000);
    endfunction

    task automatic test_reset();
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_threshold = '0; cfg_m = '0;
        model_reset(); sum_out = 0; sum_clp = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_outlier, out_clamped, out_last, tile_done} !== '0 ||
            tile_outliers !== '0 || tile_clamped !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h o=%b c=%b l=%b td=%b to=%0d tc=%0d, want all 0",
                     out_valid, out_data, out_outlier, out_clamped, out_last, tile_done, tile_outliers, tile_clamped);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic_tile();
        logic [DW-1:0] w[TL];
        exp_t e;
        w[0] = 32'd50; w[1] = -32'sd200; w[2] = 32'd300; w[3] = -32'sd400;
        cfg_threshold = 32'd100; cfg_m = 8'd2;
        for (int i = 0; i < TL; i++) begin
            drive(w[i], e);
            checks++;
            if (out_valid !== 1'b1 || out_data !== e.d || out_outlier !== e.o || out_clamped !== e.c || out_last !== e.l) begin
                errors++;
                $display("FAIL basic_beat%0d: got v=%b d=%h o=%b c=%b l=%b want d=%h o=%b c=%b l=%b",
                         i, out_valid, out_data, out_outlier, out_clamped, out_last, e.d, e.o, e.c, e.l);
            end
        end
        @(negedge clk);
        checks++;
        if (tile_done !== 1'b1 || tile_outliers !== CW'(fin_out) || tile_clamped !== CW'(fin_clp) ||
            fin_out != 2 || fin_clp != 1) begin
            errors++;
            $display("FAIL basic_done: got td=%b to=%0d tc=%0d want td=1 to=2 tc=1", tile_done, tile_outliers, tile_clamped);
        end
        sum_out = fin_out; sum_clp = fin_clp;
        @(negedge clk);
        checks++;
        if (tile_done !== 1'b0 || tile_outliers !== CW'(sum_out)) begin
            errors++; $display("FAIL done_pulse_width: got td=%b to=%0d want td=0 to=%0d", tile_done, tile_outliers, sum_out);
        end
    endtask

    task automatic test_zero_budget();
        logic [DW-1:0] w[TL];
        exp_t e;
        w[0] = 32'd5; w[1] = -32'sd5; w[2] = 32'd0; w[3] = DW'($urandom_range(1, 1000));
        cfg_threshold = 32'd0; cfg_m = 8'd0;
        for (int i = 0; i < TL; i++) begin
            drive(w[i], e);
            checks++;
            if (out_valid !== 1'b1 || out_data !== e.d || out_outlier !== e.o || out_clamped !== e.c || out_last !== e.l) begin
                errors++;
                $display("FAIL zero_budget_beat%0d: got v=%b d=%h o=%b c=%b l=%b want d=%h o=%b c=%b l=%b",
                         i, out_valid, out_data, out_outlier, out_clamped, out_last, e.d, e.o, e.c, e.l);
            end
        end
        @(negedge clk);
        checks++;
        if (tile_done !== 1'b1 || tile_outliers !== CW'(fin_out) || tile_clamped !== CW'(fin_clp)) begin
            errors++;
            $display("FAIL zero_budget_done: got td=%b to=%0d tc=%0d want 1/%0d/%0d", tile_done, tile_outliers, tile_clamped, fin_out, fin_clp);
        end
        sum_out = fin_out; sum_clp = fin_clp;
    endtask

    task automatic test_int_min();
        exp_t e;
        cfg_threshold = 32'h7FFF_FFFF; cfg_m = 8'd1;
        for (int i = 0; i < TL; i++) begin
            drive((i == 0) ? 32'h8000_0000 : rnd_word(), e);
            checks++;
            if (out_valid !== 1'b1 || out_data !== e.d || out_outlier !== e.o || out_clamped !== e.c || out_last !== e.l ||
                (i == 0 && (out_outlier !== 1'b1 || out_data !== 32'h8000_0000))) begin
                errors++;
                $display("FAIL int_min_beat%0d: got v=%b d=%h o=%b c=%b l=%b want d=%h o=%b c=%b l=%b",
                         i, out_valid, out_data, out_outlier, out_clamped, out_last, e.d, e.o, e.c, e.l);
            end
        end
        @(negedge clk);
        sum_out = fin_out; sum_clp = fin_clp;
    endtask

    task automatic test_backpressure();
        exp_t e0, e1, e2, e3;
        cfg_threshold = 32'd100; cfg_m = 8'd1;
        drive(32'd50, e0);
        drive(-32'sd500, e1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== e1.d || out_outlier !== e1.o) begin
            errors++; $display("FAIL bp_pre: got v=%b d=%h o=%b want d=%h o=%b", out_valid, out_data, out_outlier, e1.d, e1.o);
        end
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd700;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== e1.d || out_outlier !== e1.o || out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: got rdy=%b v=%b d=%h o=%b want rdy=0 v=1 d=%h o=%b",
                         k, in_ready, out_valid, out_data, out_outlier, e1.d, e1.o);
            end
        end
        out_ready = 1'b1;
        drive(32'd700, e2);
        checks++;
        if (out_valid !== 1'b1 || out_data !== e2.d || out_clamped !== e2.c || out_outlier !== e2.o || out_last !== e2.l) begin
            errors++;
            $display("FAIL bp_resume: got v=%b d=%h o=%b c=%b want d=%h o=%b c=%b", out_valid, out_data, out_outlier, out_clamped, e2.d, e2.o, e2.c);
        end
        drive(DW'($urandom_range(0, 90)), e3);
        checks++;
        if (out_data !== e3.d || out_last !== 1'b1) begin
            errors++; $display("FAIL bp_last: got d=%h l=%b want d=%h l=1", out_data, out_last, e3.d);
        end
        @(negedge clk);
        checks++;
        if (tile_done !== 1'b1 || tile_outliers !== CW'(fin_out) || tile_clamped !== CW'(fin_clp)) begin
            errors++;
            $display("FAIL bp_done: got td=%b to=%0d tc=%0d want 1/%0d/%0d", tile_done, tile_outliers, tile_clamped, fin_out, fin_clp);
        end
        sum_out = fin_out; sum_clp = fin_clp;
    endtask

    task automatic test_cfg_change();
        exp_t e;
        logic [DW-1:0] w[TL];
        w[0] = 32'd500; w[1] = -32'sd600; w[2] = 32'd700; w[3] = -32'sd800;
        cfg_threshold = 32'd10; cfg_m = 8'd3;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < TL; i++) begin
                drive(w[i], e);
                if (t == 0 && i == 0) begin
                    cfg_m = 8'd0; cfg_threshold = 32'hFFFF_FFFF;
                end
                if (t == 1 && i == 0) cfg_threshold = 32'hFFFF_FFFF;
                checks++;
                if (out_valid !== 1'b1 || out_data !== e.d || out_outlier !== e.o || out_clamped !== e.c || out_last !== e.l) begin
                    errors++;
                    $display("FAIL cfg_t%0d_beat%0d: got d=%h o=%b c=%b l=%b want d=%h o=%b c=%b l=%b",
                             t, i, out_data, out_outlier, out_clamped, out_last, e.d, e.o, e.c, e.l);
                end
            end
            @(negedge clk);
            checks++;
            if (tile_done !== 1'b1 || tile_outliers !== CW'(fin_out) || tile_clamped !== CW'(fin_clp)) begin
                errors++;
                $display("FAIL cfg_done_t%0d: got td=%b to=%0d tc=%0d want 1/%0d/%0d", t, tile_done, tile_outliers, tile_clamped, fin_out, fin_clp);
            end
            sum_out = fin_out; sum_clp = fin_clp;
            cfg_threshold = 32'd10;
        end
    endtask

    task automatic test_clear();
        exp_t e;
        cfg_threshold = 32'd10; cfg_m = 8'd2;
        drive(rnd_word(), e);
        drive(rnd_word(), e);
        clear = 1'b1; in_valid = 1'b1; in_data = 32'd999;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL clear_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        model_reset();
        checks++;
        if (out_valid !== 1'b0 || tile_done !== 1'b0 || tile_outliers !== CW'(sum_out) || tile_clamped !== CW'(sum_clp)) begin
            errors++;
            $display("FAIL clear_state: got v=%b td=%b to=%0d tc=%0d want v=0 td=0 to=%0d tc=%0d",
                     out_valid, tile_done, tile_outliers, tile_clamped, sum_out, sum_clp);
        end
        for (int i = 0; i < TL; i++) begin
            drive(rnd_word(), e);
            checks++;
            if (out_valid !== 1'b1 || out_data !== e.d || out_outlier !== e.o || out_clamped !== e.c || out_last !== e.l || tile_done !== 1'b0) begin
                errors++;
                $display("FAIL clear_tile_beat%0d: got d=%h o=%b c=%b l=%b td=%b want d=%h o=%b c=%b l=%b td=0",
                         i, out_data, out_outlier, out_clamped, out_last, tile_done, e.d, e.o, e.c, e.l);
            end
        end
        @(negedge clk);
        checks++;
        if (tile_done !== 1'b1 || tile_outliers !== CW'(fin_out) || tile_clamped !== CW'(fin_clp)) begin
            errors++;
            $display("FAIL clear_done: got td=%b to=%0d tc=%0d want 1/%0d/%0d", tile_done, tile_outliers, tile_clamped, fin_out, fin_clp);
        end
        sum_out = fin_out; sum_clp = fin_clp;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   prev_last;
        int   p_out, p_clp;
        prev_last = 1'b0; p_out = 0; p_clp = 0;
        for (int n = 0; n < 10 * TL; n++) begin
            if (m_idx == 0) begin
                cfg_threshold = DW'($urandom_range(0, 1500));
                cfg_m         = MW'($urandom_range(0, 5));
            end
            drive(rnd_word(), e);
            if (m_idx != 1 && $urandom_range(0, 1) == 1) cfg_m = MW'($urandom_range(0, 5));
            checks++;
            if (out_valid !== 1'b1 || out_data !== e.d || out_outlier !== e.o || out_clamped !== e.c || out_last !== e.l ||
                tile_done !== prev_last || (prev_last && (tile_outliers !== CW'(p_out) || tile_clamped !== CW'(p_clp)))) begin
                errors++;
                $display("FAIL b2b_beat%0d: got d=%h o=%b c=%b l=%b td=%b to=%0d tc=%0d want d=%h o=%b c=%b l=%b td=%b to=%0d tc=%0d",
                         n, out_data, out_outlier, out_clamped, out_last, tile_done, tile_outliers, tile_clamped,
                         e.d, e.o, e.c, e.l, prev_last, p_out, p_clp);
            end
            prev_last = e.l;
            if (e.l) begin p_out = fin_out; p_clp = fin_clp; end
        end
        @(negedge clk);
        checks++;
        if (tile_done !== 1'b1 || tile_outliers !== CW'(p_out) || tile_clamped !== CW'(p_clp)) begin
            errors++;
            $display("FAIL b2b_final_done: got td=%b to=%0d tc=%0d want 1/%0d/%0d", tile_done, tile_outliers, tile_clamped, p_out, p_clp);
        end
        sum_out = p_out; sum_clp = p_clp;
    endtask

    task automatic test_async_reset();
        exp_t e;
        cfg_threshold = 32'd0; cfg_m = 8'd1;
        drive(32'd77, e);
        drive(-32'sd88, e);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_outlier, out_clamped, out_last, tile_done} !== '0 ||
            tile_outliers !== '0 || tile_clamped !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h o=%b c=%b l=%b td=%b to=%0d tc=%0d, want all 0",
                     out_valid, out_data, out_outlier, out_clamped, out_last, tile_done, tile_outliers, tile_clamped);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < TL; i++) begin
            drive(rnd_word(), e);
            checks++;
            if (out_valid !== 1'b1 || out_data !== e.d || out_outlier !== e.o || out_clamped !== e.c || out_last !== e.l || tile_done !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_beat%0d: got d=%h o=%b c=%b l=%b td=%b want d=%h o=%b c=%b l=%b td=0",
                         i, out_data, out_outlier, out_clamped, out_last, tile_done, e.d, e.o, e.c, e.l);
            end
        end
        @(negedge clk);
        checks++;
        if (tile_done !== 1'b1 || tile_outliers !== CW'(fin_out) || tile_clamped !== CW'(fin_clp)) begin
            errors++;
            $display("FAIL post_reset_done: got td=%b to=%0d tc=%0d want 1/%0d/%0d", tile_done, tile_outliers, tile_clamped, fin_out, fin_clp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_tile();
        test_zero_budget();
        test_int_min();
        test_backpressure();
        test_cfg_change();
        test_clear();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
